// File: rtl/kbd_attack_entry_if.sv
// Bundle between the PS/2 byte source, the entry block and the turn controller.
// Latency: none (wires only).
// Backpressure: coord_valid/coord_ready handshake on the coordinate side; scan bytes are never stalled.
interface kbd_attack_entry_if;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       clear;
    logic       coord_ready;
    logic       coord_valid;
    logic [3:0] coord_x;
    logic [3:0] coord_y;
    logic [1:0] entry_state;
    logic       key_err;

    // Producer side: keyboard receiver plus turn controller
    modport master (
        output scan_code, scan_valid, clear, coord_ready,
        input  coord_valid, coord_x, coord_y, entry_state, key_err
    );

    // Entry block side
    modport slave (
        input  scan_code, scan_valid, clear, coord_ready,
        output coord_valid, coord_x, coord_y, entry_state, key_err
    );
endinterface

// File: rtl/kbd_attack_entry.sv
// Collects a letter+digit attack coordinate from PS/2 set-2 bytes and offers it on Enter.
// Latency: state, fields and key_err update one cycle after the consuming strobe.
// Backpressure: coordinate held in OFFER until coord_ready; scan bytes meanwhile ignored (break tracking only).
// Optional: define KBD_ATTACK_ENTRY_BACKSPACE_EN to make 0x66 step the entry back by one field.
module kbd_attack_entry #(
    parameter int DIGIT_ONE_BASED = 0
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    kbd_attack_entry_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GOT_COL = 2'd1,
        S_GOT_ROW = 2'd2,
        S_OFFER   = 2'd3
    } state_t;

    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BREAK = 8'hF0;
    localparam logic [7:0] CODE_ENTER = 8'h5A;
    localparam logic [7:0] CODE_BKSP  = 8'h66;

`ifdef KBD_ATTACK_ENTRY_BACKSPACE_EN
    localparam logic BKSP_EN = 1'b1;
`else
    localparam logic BKSP_EN = 1'b0;
`endif

    state_t     state_q, state_d;
    logic [3:0] col_q, col_d;
    logic [3:0] row_q, row_d;
    logic       brk_q, brk_d;
    logic       err_q, err_d;

    logic       let_hit;
    logic [3:0] let_col;
    logic       dig_hit;
    logic [3:0] dig_val;
    logic [3:0] dig_row;

    // Decode the incoming byte into letter column and digit row candidates
    always_comb begin
        let_hit = 1'b1;
        let_col = 4'd0;
        case (bus.scan_code)
            8'h1C:   let_col = 4'd0;
            8'h32:   let_col = 4'd1;
            8'h21:   let_col = 4'd2;
            8'h23:   let_col = 4'd3;
            8'h24:   let_col = 4'd4;
            8'h2B:   let_col = 4'd5;
            8'h34:   let_col = 4'd6;
            8'h33:   let_col = 4'd7;
            8'h43:   let_col = 4'd8;
            8'h3B:   let_col = 4'd9;
            default: let_hit = 1'b0;
        endcase
        dig_hit = 1'b1;
        dig_val = 4'd0;
        case (bus.scan_code)
            8'h45:   dig_val = 4'd0;
            8'h16:   dig_val = 4'd1;
            8'h1E:   dig_val = 4'd2;
            8'h26:   dig_val = 4'd3;
            8'h25:   dig_val = 4'd4;
            8'h2E:   dig_val = 4'd5;
            8'h36:   dig_val = 4'd6;
            8'h3D:   dig_val = 4'd7;
            8'h3E:   dig_val = 4'd8;
            8'h46:   dig_val = 4'd9;
            default: dig_hit = 1'b0;
        endcase
        // One-based boards print '0' after '9', so '0' becomes the last row
        if (DIGIT_ONE_BASED != 0) begin
            dig_row = (dig_val == 4'd0) ? 4'd9 : dig_val - 4'd1;
        end else begin
            dig_row = dig_val;
        end
    end

    // State and field registers; reset discards any entry in progress
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            col_q   <= 4'd0;
            row_q   <= 4'd0;
            brk_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            brk_q   <= brk_d;
            err_q   <= err_d;
        end
    end

    // Next state: clear beats the handshake, which beats any scan byte
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        brk_d   = brk_q;
        err_d   = 1'b0;
        if (bus.clear) begin
            state_d = S_IDLE;
        end else if ((state_q == S_OFFER) && bus.coord_ready) begin
            state_d = S_IDLE;
        end else if (bus.scan_valid && (bus.scan_code != CODE_EXT)) begin
            if (brk_q) begin
                // Byte after F0 is the released key: swallow it
                brk_d = 1'b0;
            end else if (bus.scan_code == CODE_BREAK) begin
                brk_d = 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (let_hit) begin
                            col_d   = let_col;
                            state_d = S_GOT_COL;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    S_GOT_COL: begin
                        if (let_hit) begin
                            col_d = let_col;
                        end else if (dig_hit) begin
                            row_d   = dig_row;
                            state_d = S_GOT_ROW;
                        end else if (BKSP_EN && (bus.scan_code == CODE_BKSP)) begin
                            state_d = S_IDLE;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    S_GOT_ROW: begin
                        if (dig_hit) begin
                            row_d = dig_row;
                        end else if (let_hit) begin
                            col_d   = let_col;
                            state_d = S_GOT_COL;
                        end else if (bus.scan_code == CODE_ENTER) begin
                            state_d = S_OFFER;
                        end else if (BKSP_EN && (bus.scan_code == CODE_BKSP)) begin
                            row_d   = 4'd0;
                            state_d = S_GOT_COL;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    default: begin
                        // OFFER: coordinate frozen until accepted
                    end
                endcase
            end
        end
    end

    // Outputs are straight decodes of registered state
    always_comb begin
        bus.coord_valid = (state_q == S_OFFER);
        bus.coord_x     = col_q;
        bus.coord_y     = row_q;
        bus.entry_state = state_q;
        bus.key_err     = err_q;
    end

endmodule

// File: tb/tb_kbd_attack_entry.sv
module tb_kbd_attack_entry;

    logic       clk;
    logic       resetn;
    logic [7:0] code;
    logic       vld;
    logic       clr;
    logic       rdy;

    int checks = 0;
    int errors = 0;

    kbd_attack_entry_if bus0 ();
    kbd_attack_entry_if bus1 ();

    assign bus0.scan_code   = code;
    assign bus0.scan_valid  = vld;
    assign bus0.clear       = clr;
    assign bus0.coord_ready = rdy;
    assign bus1.scan_code   = code;
    assign bus1.scan_valid  = vld;
    assign bus1.clear       = clr;
    assign bus1.coord_ready = rdy;

    kbd_attack_entry #(.DIGIT_ONE_BASED(0)) dut0 (.CLOCK_50(clk), .resetn(resetn), .bus(bus0));
    kbd_attack_entry #(.DIGIT_ONE_BASED(1)) dut1 (.CLOCK_50(clk), .resetn(resetn), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] let_codes [10] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B};
    logic [7:0] dig_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    // Expected outputs per instance (index = DIGIT_ONE_BASED value)
    int m_st  [2] = '{0, 0};
    int m_col [2] = '{0, 0};
    int m_row [2] = '{0, 0};
    int m_brk [2] = '{0, 0};
    int m_err [2] = '{0, 0};

    function automatic int find_code(input logic [7:0] c, input logic [7:0] tbl [10]);
        for (int k = 0; k < 10; k++) begin
            if (tbl[k] == c) return k;
        end
        return -1;
    endfunction

    // Entry model: a letter always yields "have column", a digit needs a column first,
    // Enter needs both, anything unrecognised outside OFFER is an error.
    always @(posedge clk) begin
        int li;
        int di;
        for (int i = 0; i < 2; i++) begin
            if (!resetn) begin
                m_st[i] = 0; m_col[i] = 0; m_row[i] = 0; m_brk[i] = 0; m_err[i] = 0;
            end else begin
                m_err[i] = 0;
                if (clr) begin
                    m_st[i] = 0;
                end else if (m_st[i] == 3 && rdy) begin
                    m_st[i] = 0;
                end else if (vld && code != 8'hE0) begin
                    li = find_code(code, let_codes);
                    di = find_code(code, dig_codes);
                    if (m_brk[i] != 0) m_brk[i] = 0;
                    else if (code == 8'hF0) m_brk[i] = 1;
                    else if (m_st[i] != 3) begin
                        if (li >= 0) begin
                            m_col[i] = li; m_st[i] = 1;
                        end else if (di >= 0 && m_st[i] != 0) begin
                            m_row[i] = (i == 1) ? (di + 9) % 10 : di;
                            m_st[i] = 2;
                        end else if (code == 8'h5A && m_st[i] == 2) begin
                            m_st[i] = 3;
`ifdef KBD_ATTACK_ENTRY_BACKSPACE_EN
                        end else if (code == 8'h66 && m_st[i] == 2) begin
                            m_st[i] = 1; m_row[i] = 0;
                        end else if (code == 8'h66 && m_st[i] == 1) begin
                            m_st[i] = 0;
`endif
                        end else begin
                            m_err[i] = 1;
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input int i, input logic [1:0] st, input logic cv,
                            input logic [3:0] x, input logic [3:0] y, input logic ke);
        chk($sformatf("dut%0d.entry_state", i), int'(st), m_st[i]);
        chk($sformatf("dut%0d.coord_valid", i), int'(cv), (m_st[i] == 3) ? 1 : 0);
        chk($sformatf("dut%0d.coord_x", i), int'(x), m_col[i]);
        chk($sformatf("dut%0d.coord_y", i), int'(y), m_row[i]);
        chk($sformatf("dut%0d.key_err", i), int'(ke), m_err[i]);
    endtask

    // Each cycle: compare both instances against the model, then apply new inputs
    task automatic drive(input logic [7:0] c, input logic v, input logic cl, input logic r);
        @(negedge clk);
        if (resetn) begin
            cmp_inst(0, bus0.entry_state, bus0.coord_valid, bus0.coord_x, bus0.coord_y, bus0.key_err);
            cmp_inst(1, bus1.entry_state, bus1.coord_valid, bus1.coord_x, bus1.coord_y, bus1.key_err);
        end
        code = c; vld = v; clr = cl; rdy = r;
    endtask

    task automatic key(input logic [7:0] c);
        drive(c, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle();
        drive(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".state0"}, int'(bus0.entry_state), 0);
        chk({tag, ".valid0"}, int'(bus0.coord_valid), 0);
        chk({tag, ".x0"}, int'(bus0.coord_x), 0);
        chk({tag, ".y0"}, int'(bus0.coord_y), 0);
        chk({tag, ".err0"}, int'(bus0.key_err), 0);
        chk({tag, ".y1"}, int'(bus1.coord_y), 0);
    endtask

    initial begin
        resetn = 1'b0; code = 8'h00; vld = 1'b0; clr = 1'b0; rdy = 1'b0;
        #12;
        chk_zero("reset");
        @(negedge clk);
        resetn = 1'b1;

        // G5 Enter with coord_ready already high
        drive(8'h34, 1'b1, 1'b0, 1'b1);
        drive(8'h2E, 1'b1, 1'b0, 1'b1);
        drive(8'h5A, 1'b1, 1'b0, 1'b1);
        drive(8'h00, 1'b0, 1'b0, 1'b1);
        chk("g5.valid", int'(bus0.coord_valid), 1);
        chk("g5.x", int'(bus0.coord_x), 6);
        chk("g5.y", int'(bus0.coord_y), 5);
        chk("g5.y_onebased", int'(bus1.coord_y), 4);
        idle();
        chk("g5.idle", int'(bus0.entry_state), 0);
        chk("g5.valid_drop", int'(bus0.coord_valid), 0);

        // A, break A (discarded), 1
        key(8'h1C); key(8'hF0); key(8'h1C); key(8'h16);
        idle();
        chk("brk.state", int'(bus0.entry_state), 2);
        chk("brk.x", int'(bus0.coord_x), 0);
        chk("brk.y", int'(bus0.coord_y), 1);
        chk("brk.y_onebased", int'(bus1.coord_y), 0);

        // Stall in OFFER while C is hammered, then accept with C arriving in the accept cycle
        key(8'h5A);
        for (int k = 0; k < 20; k++) drive(8'h21, 1'b1, 1'b0, 1'b0);
        drive(8'h21, 1'b1, 1'b0, 1'b1);
        chk("stall.valid", int'(bus0.coord_valid), 1);
        chk("stall.x", int'(bus0.coord_x), 0);
        idle();
        chk("stall.state_after", int'(bus0.entry_state), 0);
        chk("stall.x_after", int'(bus0.coord_x), 0);

        // Digit in IDLE is rejected with a one-cycle pulse
        key(8'h16);
        idle();
        chk("err.pulse", int'(bus0.key_err), 1);
        chk("err.state", int'(bus0.entry_state), 0);
        idle();
        chk("err.width", int'(bus0.key_err), 0);

        // Extended keypad Enter, then accept
        key(8'h2B); key(8'h3D); key(8'hE0); key(8'h5A);
        idle();
        chk("kpenter.valid", int'(bus0.coord_valid), 1);
        drive(8'h00, 1'b0, 1'b0, 1'b1);

        // Break tracking continues in OFFER; released key after F0 swallowed
        key(8'h24); key(8'h26); key(8'h5A);
        key(8'hF0); key(8'h1C); key(8'h99);
        drive(8'h00, 1'b0, 1'b0, 1'b1);
        idle();

        // Clear wins over a letter strobe and over the handshake
        key(8'h43); key(8'h3E);
        drive(8'h1C, 1'b1, 1'b1, 1'b0);
        idle();
        chk("clr.state", int'(bus0.entry_state), 0);
        chk("clr.x", int'(bus0.coord_x), 8);
        key(8'h43); key(8'h3E); key(8'h5A);
        drive(8'h00, 1'b0, 1'b1, 1'b1);
        idle();
        chk("clr_offer.valid", int'(bus0.coord_valid), 0);

        // Clear keeps a pending break
        key(8'hF0);
        drive(8'h00, 1'b0, 1'b1, 1'b0);
        key(8'h1C);
        idle();
        chk("clr_brk.state", int'(bus0.entry_state), 0);
        chk("clr_brk.err", int'(bus0.key_err), 0);

        // Backspace handling
        key(8'h3B); key(8'h46); key(8'h66);
`ifdef KBD_ATTACK_ENTRY_BACKSPACE_EN
        key(8'h45); key(8'h5A);
        idle();
        chk("bksp.valid", int'(bus0.coord_valid), 1);
        chk("bksp.x", int'(bus0.coord_x), 9);
        chk("bksp.y", int'(bus0.coord_y), 0);
        drive(8'h00, 1'b0, 1'b0, 1'b1);
`else
        idle();
        chk("bksp.err", int'(bus0.key_err), 1);
        chk("bksp.state", int'(bus0.entry_state), 2);
        drive(8'h00, 1'b0, 1'b1, 1'b0);
`endif
        idle();

        // Every letter/digit pair through a full offer
        for (int k = 0; k < 10; k++) begin
            key(let_codes[k]); key(dig_codes[k]); key(8'h5A);
            idle();
            chk("sweep.x", int'(bus0.coord_x), k);
            chk("sweep.y", int'(bus0.coord_y), k);
            drive(8'h00, 1'b0, 1'b0, 1'b1);
        end
        idle();

        // Asynchronous reset in GOT_ROW
        key(8'h33); key(8'h3E);
        idle();
        @(posedge clk);
        #2 resetn = 1'b0;
        #1 chk_zero("async_rst");
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        idle(); idle();
        chk("post_rst.state", int'(bus0.entry_state), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
